seq_det_ctrl: RTL and testbench
===============================

Name: seq_det_ctrl

Overview:
- Front-end sequencer for the team's serial pattern detector.
- Accepts parallel words over a valid/ready handshake and serialises them MSB-first into a continuous bit stream.
- Runs a runtime-programmable overlapping pattern match (up to PAT_W bits) on that stream.
- Counts matches and raises a sticky interrupt when a programmed threshold is reached.

Parameters:
- DATA_W, 8: width of each input word, serialised MSB-first.
- PAT_W, 3: maximum pattern length in bits (≥2).
- CNT_W, 8: width of the match counter and the threshold.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous reset, active-low. Assert asynchronously; release synchronously with clk.
- cfg_we  in  1  configuration write strobe.
- cfg_pattern  in  PAT_W  match pattern, right-aligned; bit 0 is the most recently received bit.
- cfg_len  in  4  pattern length. Values 0 or >PAT_W are treated as PAT_W.
- cfg_thresh  in  CNT_W  irq threshold. 0 disables irq.
- s_valid  in  1  input word valid.
- s_data  in  DATA_W  input word.
- s_ready  out  1  word accepted when s_valid && s_ready.
- bit_valid  out  1  a serial bit is being emitted this cycle.
- bit_out  out  1  the serial bit.
- match  out  1  one-cycle pulse per detected pattern.
- match_cnt  out  CNT_W  saturating match count.
- irq  out  1  sticky threshold interrupt.
- irq_clr  in  1  clears irq.
- busy  out  1  high when state is SHIFT.

Behaviour:
- Reset values: state IDLE, shift reg 0, bit_idx 0, history 0, hist_cnt 0, pattern 0, len PAT_W, thresh 0, match 0, match_cnt 0, irq 0, bit_valid 0, bit_out 0.
- s_ready is 1 immediately after reset is released while in IDLE.
- FSM states:
  - IDLE: s_ready = !cfg_we.
    - If cfg_we: load pattern, len and thresh; clear history, hist_cnt, match_cnt and irq; stay IDLE.
    - Else if s_valid: load the shift reg, set bit_idx=0, go to SHIFT.
  - SHIFT: bit_valid=1, bit_out = shift_reg[DATA_W-1-bit_idx]. bit_idx increments each cycle.
    - s_ready = (bit_idx == DATA_W-1), i.e. high only in the last bit cycle.
    - On the last bit, with s_valid: load the next word and stay in SHIFT. Back-to-back words give no bubble.
    - On the last bit, without s_valid: go to IDLE.
- Handshake: s_data is sampled only on a s_valid && s_ready edge. A word is emitted in exactly DATA_W consecutive bit_valid cycles.
- cfg_we in SHIFT is ignored entirely. cfg_we has priority over s_valid in IDLE.
- Detector: on each clk edge with bit_valid:
  - history <= {history[PAT_W-2:0], bit_out}.
  - hist_cnt saturates at PAT_W.
  - The match condition is evaluated on the updated history: hist_cnt_next ≥ len and history_next[len-1:0] == pattern[len-1:0].
  - If the condition holds, match is registered high for exactly one cycle, i.e. the cycle after the completing bit's bit_valid cycle.
  - Overlapping matches count.
  - History persists across word boundaries and IDLE gaps. It is cleared only by reset or cfg_we.
- Counter: match_cnt increments by 1 in the same edge that sets match, and saturates at all-ones.
- irq: set on the edge where match_cnt changes to a value equal to thresh, with thresh ≠ 0.
  - Cleared by irq_clr. If set and clear occur on the same edge, set wins.
  - A saturated counter does not re-fire irq.
- Reset mid-word: all state clears asynchronously. The partial word is discarded and not resumed.

Test Plan:
1. Program pattern=3'b101, len=3, thresh=0. Send 8'b0010_1011. Required:
   - bit_out sequence 0,0,1,0,1,0,1,1 over 8 bit_valid cycles.
   - match pulses one cycle after bit indices 4 and 6.
   - match_cnt=2, irq stays 0.
2. Same pattern, with s_valid held for 8'h02 then 8'h80. Required:
   - 16 continuous bit_valid cycles.
   - s_ready high only in cycle 8 and cycle 16.
   - Exactly one match, one cycle after the first bit of the second word (cross-boundary overlap).
3. pattern=2'b11, len=2, thresh=3. Send 8'hFF. Required:
   - 7 match pulses (the first after the 2nd bit).
   - irq rises with the 3rd match and stays high.
   - irq_clr pulse drops irq the next cycle; no re-fire at counts 4–7.
4. Issue cfg_we (pattern 3'b111) during SHIFT of a 3'b101 run. Required:
   - Config unchanged; match_cnt not cleared; matches continue on 101.
   - cfg_we in IDLE with s_valid=1 gives s_ready=0 that cycle; the word is accepted the next cycle.
5. Drive rst low at bit index 3 of a word. Required:
   - bit_valid, match, match_cnt, irq and busy go to 0 immediately.
   - After release: s_ready=1, len=PAT_W, and the next word is serialised from its MSB.
6. cfg_len=0 with pattern 3'b110. Required:
   - Behaves as len=3.
   - Input 8'b1101_1000 gives matches after bit indices 2 and 5 (windows 110 at bits 0–2 and bits 3–5).

Source files
------------

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl
// Front-end sequencer for the serial pattern detector. Parallel words arrive
// over a valid/ready handshake and are serialised MSB-first into a continuous
// bit stream. An overlapping pattern match of up to PAT_W bits runs on that
// stream. Matches are counted with saturation, and a sticky interrupt is
// raised when the count reaches a programmed threshold.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   cfg_we       configuration write strobe (honoured only while idle)
//   cfg_pattern  match pattern, right-aligned; bit 0 is the newest bit
//   cfg_len      pattern length; 0 or values above PAT_W mean PAT_W
//   cfg_thresh   interrupt threshold; 0 disables the interrupt
//   s_valid      input word valid
//   s_data       input word
//   s_ready      word accepted when s_valid && s_ready
//   bit_valid    a serial bit is emitted this cycle
//   bit_out      the serial bit
//   match        one-cycle pulse per detected pattern
//   match_cnt    saturating match count
//   irq          sticky threshold interrupt
//   irq_clr      clears irq
//   busy         high while a word is being shifted out
module seq_det_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [3:0]        cfg_len,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              bit_valid,
  output logic              bit_out,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              irq,
  input  logic              irq_clr,
  output logic              busy
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [3:0] FULL_LEN = 4'(PAT_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [IDX_W-1:0]  bit_idx;
  logic [PAT_W-1:0]  history;
  logic [PAT_W-1:0]  pattern;
  logic [3:0]        hist_cnt;
  logic [3:0]        len;
  logic [CNT_W-1:0]  thresh;

  logic              last_bit;
  logic [PAT_W-1:0]  history_next;
  logic [3:0]        hist_cnt_next;
  logic [PAT_W-1:0]  len_mask;
  logic [3:0]        cfg_len_eff;
  logic              hit;
  logic              cnt_sat;
  logic [CNT_W-1:0]  cnt_inc;

  // The shift register moves left every bit, so the current bit is always
  // the MSB; this is the same bit as shift_reg[DATA_W-1-bit_idx] of the
  // originally loaded word.
  assign busy      = (state == SHIFT);
  assign bit_valid = busy;
  assign bit_out   = busy & shift_reg[DATA_W-1];
  assign last_bit  = (bit_idx == LAST_IDX);
  assign s_ready   = busy ? last_bit : !cfg_we;

  assign history_next  = {history[PAT_W-2:0], bit_out};
  assign hist_cnt_next = (hist_cnt == FULL_LEN) ? hist_cnt : hist_cnt + 4'd1;
  assign cfg_len_eff   = ((cfg_len == 4'd0) || (cfg_len > FULL_LEN)) ? FULL_LEN : cfg_len;
  assign cnt_sat       = &match_cnt;
  assign cnt_inc       = match_cnt + CNT_W'(1);

  // Only the low 'len' history bits take part in the comparison.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (4'(i) < len);
    end
  end

  // The match is judged on the history as it will be after this bit, and
  // only once enough bits have been seen to fill the pattern window.
  assign hit = bit_valid && (hist_cnt_next >= len) &&
               (((history_next ^ pattern) & len_mask) == '0);

  // Sequencer, detector, counter and interrupt share one register block.
  // In IDLE bit_valid is low, so the detector path never collides with the
  // configuration clear below.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      history   <= '0;
      hist_cnt  <= 4'd0;
      pattern   <= '0;
      len       <= FULL_LEN;
      thresh    <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
      irq       <= 1'b0;
    end else begin
      match <= hit;

      if (hit && !cnt_sat) begin
        match_cnt <= cnt_inc;
      end

      // Setting takes priority over a simultaneous clear; a saturated
      // counter no longer changes, so it cannot fire again.
      if (hit && !cnt_sat && (thresh != '0) && (cnt_inc == thresh)) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end

      if (bit_valid) begin
        history  <= history_next;
        hist_cnt <= hist_cnt_next;
      end

      case (state)
        IDLE: begin
          if (cfg_we) begin
            pattern   <= cfg_pattern;
            len       <= cfg_len_eff;
            thresh    <= cfg_thresh;
            history   <= '0;
            hist_cnt  <= 4'd0;
            match_cnt <= '0;
            irq       <= 1'b0;
          end else if (s_valid) begin
            shift_reg <= s_data;
            bit_idx   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            bit_idx <= '0;
            if (s_valid) begin
              shift_reg <= s_data;
            end else begin
              state <= IDLE;
            end
          end else begin
            shift_reg <= shift_reg << 1;
            bit_idx   <= bit_idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl
// Self-checking bench for seq_det_ctrl: a table of single/double word runs
// with hand-computed match timing, plus hand-written sequences for irq
// clearing, configuration writes during shifting and reset mid-word.
module tb_seq_det_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [2:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_thresh;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       bit_valid;
  logic       bit_out;
  logic       match;
  logic [7:0] match_cnt;
  logic       irq;
  logic       irq_clr;
  logic       busy;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [2:0]  pattern;
    logic [3:0]  len;
    logic [7:0]  thresh;
    logic [7:0]  w0;
    logic [7:0]  w1;
    bit          two;
    logic [16:0] exp_match;
    logic [7:0]  exp_cnt;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[6];

  seq_det_ctrl #(.DATA_W(8), .PAT_W(3), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_thresh(cfg_thresh),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .bit_valid(bit_valid),
    .bit_out(bit_out),
    .match(match),
    .match_cnt(match_cnt),
    .irq(irq),
    .irq_clr(irq_clr),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic configure(input logic [2:0] pat, input logic [3:0] l, input logic [7:0] th);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = l;
    cfg_thresh  = th;
    s_valid     = 1'b0;
    tick();
    cfg_we = 1'b0;
  endtask

  // Program a row, hand over its word(s), then watch every cycle until the
  // sequencer is back in IDLE. Cycle k is the k-th cycle after acceptance.
  task automatic applyStimulus(input int idx, input vec_t v);
    int          n;
    logic [15:0] wd;
    logic [15:0] obs_bits;
    logic [15:0] exp_bits;
    logic [16:0] obs_valid;
    logic [16:0] exp_valid;
    logic [16:0] obs_ready;
    logic [16:0] exp_ready;
    logic [16:0] obs_match;
    n  = v.two ? 16 : 8;
    wd = v.two ? {v.w0, v.w1} : {v.w0, 8'h00};
    obs_bits = '0; exp_bits = '0; obs_valid = '0; exp_valid = '0;
    obs_ready = '0; exp_ready = '0; obs_match = '0;
    configure(v.pattern, v.len, v.thresh);
    s_valid = 1'b1;
    s_data  = v.w0;
    #1;
    checkOutput($sformatf("row%0d_ready_idle", idx), 32'(s_ready), 32'd1);
    tick();
    for (int k = 0; k <= n; k++) begin
      if (v.two && k < 8) begin
        s_valid = 1'b1;
        s_data  = v.w1;
      end else begin
        s_valid = 1'b0;
      end
      #1;
      obs_valid[k] = bit_valid;
      obs_ready[k] = s_ready;
      obs_match[k] = match;
      if (k < n) begin
        obs_bits[k]  = bit_out;
        exp_bits[k]  = wd[15-k];
        exp_valid[k] = 1'b1;
        exp_ready[k] = ((k % 8) == 7);
      end else begin
        exp_ready[k] = 1'b1;
      end
      if (k < n) tick();
    end
    checkOutput($sformatf("row%0d_bits", idx), 32'(obs_bits), 32'(exp_bits));
    checkOutput($sformatf("row%0d_valid", idx), 32'(obs_valid), 32'(exp_valid));
    checkOutput($sformatf("row%0d_ready", idx), 32'(obs_ready), 32'(exp_ready));
    checkOutput($sformatf("row%0d_match", idx), 32'(obs_match), 32'(v.exp_match));
    checkOutput($sformatf("row%0d_cnt", idx), 32'(match_cnt), 32'(v.exp_cnt));
    checkOutput($sformatf("row%0d_irq", idx), 32'(irq), 32'(v.exp_irq));
    tick();
  endtask

  initial begin
    logic [8:0]  obs_irq;
    logic [16:0] obs_match;
    logic [7:0]  obs_bits;
    int          pulses;

    tests_run    = 0;
    tests_failed = 0;

    // Rows: pattern, len, thresh, w0, w1, two, match cycles, cnt, irq
    vecs[0] = '{3'b101, 4'd3, 8'd0, 8'h2B, 8'h00, 1'b0, 17'h000A0, 8'd2, 1'b0};
    vecs[1] = '{3'b101, 4'd3, 8'd0, 8'h02, 8'h80, 1'b1, 17'h00200, 8'd1, 1'b0};
    vecs[2] = '{3'b110, 4'd0, 8'd0, 8'hD8, 8'h00, 1'b0, 17'h00048, 8'd2, 1'b0};
    vecs[3] = '{3'b001, 4'd2, 8'd2, 8'h55, 8'h00, 1'b0, 17'h00154, 8'd4, 1'b1};
    vecs[4] = '{3'b111, 4'd5, 8'd1, 8'hE0, 8'h00, 1'b0, 17'h00008, 8'd1, 1'b1};
    vecs[5] = '{3'b000, 4'd3, 8'd6, 8'h00, 8'h00, 1'b0, 17'h001F8, 8'd6, 1'b1};

    rst = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_thresh = '0;
    s_valid = 1'b0; s_data = '0; irq_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reset_ready", 32'(s_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_bit_valid", 32'(bit_valid), 32'd0);
    checkOutput("reset_match", 32'(match), 32'd0);
    checkOutput("reset_cnt", 32'(match_cnt), 32'd0);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    tick();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // irq: rises with the 3rd match even though irq_clr is high on that
    // edge, then a later irq_clr drops it for good.
    configure(3'b011, 4'd2, 8'd3);
    s_valid = 1'b1; s_data = 8'hFF;
    tick();
    s_valid = 1'b0;
    obs_irq = '0; pulses = 0;
    for (int k = 0; k <= 8; k++) begin
      irq_clr = (k == 3 || k == 5);
      #1;
      obs_irq[k] = irq;
      if (match) pulses++;
      if (k < 8) tick();
    end
    irq_clr = 1'b0;
    checkOutput("irq_profile", 32'(obs_irq), 32'h030);
    checkOutput("irq_pulses", 32'(pulses), 32'd7);
    checkOutput("irq_cnt", 32'(match_cnt), 32'd7);
    tick();

    // cfg_we during SHIFT must be ignored completely.
    configure(3'b101, 4'd3, 8'd0);
    s_valid = 1'b1; s_data = 8'h2B;
    tick();
    s_valid = 1'b0;
    obs_match = '0;
    for (int k = 0; k <= 8; k++) begin
      cfg_we = (k == 2); cfg_pattern = 3'b111; cfg_thresh = 8'd1;
      #1;
      obs_match[k] = match;
      if (k < 8) tick();
    end
    cfg_we = 1'b0;
    checkOutput("shiftcfg_match", 32'(obs_match), 32'h0A0);
    checkOutput("shiftcfg_cnt", 32'(match_cnt), 32'd2);
    checkOutput("shiftcfg_irq", 32'(irq), 32'd0);
    tick();

    // cfg_we beats s_valid in IDLE; the word goes in the following cycle.
    cfg_we = 1'b1; cfg_pattern = 3'b101; cfg_len = 4'd3; cfg_thresh = 8'd0;
    s_valid = 1'b1; s_data = 8'h2B;
    #1;
    checkOutput("idlecfg_ready_low", 32'(s_ready), 32'd0);
    tick();
    cfg_we = 1'b0;
    #1;
    checkOutput("idlecfg_still_idle", 32'(busy), 32'd0);
    checkOutput("idlecfg_cnt_cleared", 32'(match_cnt), 32'd0);
    checkOutput("idlecfg_ready_high", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    checkOutput("idlecfg_accepted", 32'(busy), 32'd1);
    repeat (9) tick();

    // Reset at bit index 3 of a word clears everything at once.
    configure(3'b011, 4'd2, 8'd1);
    s_valid = 1'b1; s_data = 8'hFF;
    tick();
    s_valid = 1'b0;
    repeat (3) tick();
    checkOutput("prerst_match", 32'(match), 32'd1);
    checkOutput("prerst_irq", 32'(irq), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rst_bit_valid", 32'(bit_valid), 32'd0);
    checkOutput("rst_match", 32'(match), 32'd0);
    checkOutput("rst_cnt", 32'(match_cnt), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("postrst_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1; s_data = 8'h80;
    tick();
    s_valid = 1'b0;
    obs_bits = '0; obs_match = '0;
    for (int k = 0; k <= 8; k++) begin
      #1;
      if (k < 8) obs_bits[k] = bit_out;
      obs_match[k] = match;
      if (k < 8) tick();
    end
    checkOutput("postrst_bits", 32'(obs_bits), 32'h01);
    checkOutput("postrst_match", 32'(obs_match), 32'h1F0);
    checkOutput("postrst_cnt", 32'(match_cnt), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
